// File: rtl/xenos_pkg.sv
// Shared types and constants for the XENOS fault manager.
//   fault_type_t : one-hot fault code bits reported by the boundary checker
//   chan_state_t : per-channel guard FSM state encoding (3 bits)
package xenos_pkg;

  localparam int unsigned XENOS_NUM_CH  = 12;
  localparam int unsigned XENOS_CODE_W  = 4;
  localparam int unsigned XENOS_STATE_W = 3;

  typedef enum logic [3:0] {
    FT_NONE       = 4'b0000,
    FT_OVER_VOLT  = 4'b0001,
    FT_UNDER_VOLT = 4'b0010,
    FT_OVER_CURR  = 4'b0100,
    FT_OVER_TEMP  = 4'b1000
  } fault_type_t;

  typedef enum logic [2:0] {
    ST_OK       = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_TRIP     = 3'd2,
    ST_COOL     = 3'd3,
    ST_RETRY    = 3'd4,
    ST_LOCK     = 3'd5
  } chan_state_t;

endpackage

// File: rtl/xenos_chan_guard.sv
// One channel's fault guard: debounce, trip, cool-down, retry and lockout.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   sample_valid       : checker strobe for this channel
//   fault_flag         : checker fault flag, qualified by sample_valid
//   code               : 4-bit fault code accompanying the sample
//   host_clear         : host clear pulse (releases LOCK, clears sticky/retry)
//   enable             : registered channel enable
//   state              : registered FSM state
//   sticky             : accumulated fault code bits since the last clear
//   lockout            : registered LOCK indication
module xenos_chan_guard
  import xenos_pkg::*;
#(
  parameter int unsigned DEB_CNT   = 3,
  parameter int unsigned COOL_CYC  = 1000,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned GOOD_CNT  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic       fault_flag,
  input  logic [3:0] code,
  input  logic       host_clear,
  output logic       enable,
  output logic [2:0] state,
  output logic [3:0] sticky,
  output logic       lockout
);

  localparam int unsigned TW = $clog2(COOL_CYC + 1);
  localparam int unsigned DW = $clog2(DEB_CNT + 1);
  localparam int unsigned GW = $clog2(GOOD_CNT + 1);
  // MAX_RETRY may be 0; keep the retry counter at least one bit wide
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  chan_state_t   state_q,   state_d;
  logic [TW-1:0] timer_q,   timer_d;
  logic [DW-1:0] deb_q,     deb_d;
  logic [GW-1:0] good_q,    good_d;
  logic [RW-1:0] retry_q,   retry_d;
  logic [3:0]    sticky_q,  sticky_d;
  logic          enable_q,  enable_d;
  logic          lockout_q, lockout_d;

  logic fault_s;
  logic clean_s;
  logic accepts_s;

  assign fault_s   = sample_valid & fault_flag;
  assign clean_s   = sample_valid & ~fault_flag;
  // States in which samples are looked at (COOL, TRIP and LOCK ignore them)
  assign accepts_s = (state_q == ST_OK) || (state_q == ST_DEBOUNCE) || (state_q == ST_RETRY);

  // Next-state and counter logic
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    deb_d    = deb_q;
    good_d   = good_q;
    // host clear is applied first so a same-cycle fault sample is ORed on top
    retry_d  = host_clear ? '0 : retry_q;
    sticky_d = host_clear ? '0 : sticky_q;

    if (fault_s) begin
      good_d = '0;
      if (accepts_s) begin
        sticky_d = sticky_d | code;
      end
    end

    case (state_q)
      ST_OK: begin
        if (fault_s) begin
          deb_d   = DW'(1);
          state_d = (DEB_CNT == 1) ? ST_TRIP : ST_DEBOUNCE;
        end else if (clean_s) begin
          if (good_q != GW'(GOOD_CNT)) begin
            good_d = good_q + GW'(1);
          end
          if (good_d == GW'(GOOD_CNT)) begin
            retry_d = '0;
          end
        end
      end

      ST_DEBOUNCE: begin
        if (fault_s) begin
          if (deb_q != DW'(DEB_CNT)) begin
            deb_d = deb_q + DW'(1);
          end
          if (deb_d == DW'(DEB_CNT)) begin
            state_d = ST_TRIP;
          end
        end else if (clean_s) begin
          deb_d   = '0;
          state_d = ST_OK;
        end
      end

      ST_TRIP: begin
        deb_d = '0;
        if (retry_d == RW'(MAX_RETRY)) begin
          state_d = ST_LOCK;
        end else begin
          retry_d = retry_d + RW'(1);
          timer_d = TW'(COOL_CYC - 1);
          state_d = ST_COOL;
        end
      end

      ST_COOL: begin
        if (timer_q == '0) begin
          state_d = ST_RETRY;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      ST_RETRY: begin
        if (fault_s) begin
          state_d = ST_TRIP;
        end else if (clean_s) begin
          deb_d   = '0;
          good_d  = GW'(1);
          state_d = ST_OK;
        end
      end

      ST_LOCK: begin
        if (host_clear) begin
          deb_d   = '0;
          good_d  = '0;
          state_d = ST_OK;
        end
      end

      default: begin
        state_d = ST_OK;
      end
    endcase

    enable_d  = !((state_d == ST_TRIP) || (state_d == ST_COOL) || (state_d == ST_LOCK));
    lockout_d = (state_d == ST_LOCK);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_OK;
      timer_q   <= '0;
      deb_q     <= '0;
      good_q    <= '0;
      retry_q   <= '0;
      sticky_q  <= '0;
      enable_q  <= 1'b1;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      deb_q     <= deb_d;
      good_q    <= good_d;
      retry_q   <= retry_d;
      sticky_q  <= sticky_d;
      enable_q  <= enable_d;
      lockout_q <= lockout_d;
    end
  end

  assign enable  = enable_q;
  assign state   = state_q;
  assign sticky  = sticky_q;
  assign lockout = lockout_q;

endmodule

// File: rtl/xenos_fault_manager.sv
// Per-channel fault response controller for the XENOS boundary checker.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   chk_valid      : per-channel sample strobe
//   channel_fault  : per-channel fault flag (qualified by chk_valid)
//   fault_code     : per-channel 4-bit fault code, bits [4i+3:4i]
//   host_clear     : per-channel host clear pulse
//   ch_enable      : per-channel run enable
//   ch_state       : per-channel FSM state, bits [3i+2:3i]
//   sticky_code    : per-channel accumulated fault code
//   lockout        : per-channel LOCK indication
//   irq            : any channel in TRIP
//   fault_any      : any channel not in OK
module xenos_fault_manager
  import xenos_pkg::*;
#(
  parameter int unsigned NUM_CH    = XENOS_NUM_CH,
  parameter int unsigned DEB_CNT   = 3,
  parameter int unsigned COOL_CYC  = 1000,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned GOOD_CNT  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     chk_valid,
  input  logic [NUM_CH-1:0]     channel_fault,
  input  logic [4*NUM_CH-1:0]   fault_code,
  input  logic [NUM_CH-1:0]     host_clear,
  output logic [NUM_CH-1:0]     ch_enable,
  output logic [3*NUM_CH-1:0]   ch_state,
  output logic [4*NUM_CH-1:0]   sticky_code,
  output logic [NUM_CH-1:0]     lockout,
  output logic                  irq,
  output logic                  fault_any
);

  logic [NUM_CH-1:0] in_trip;
  logic [NUM_CH-1:0] not_ok;

  // One independent guard per channel
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    xenos_chan_guard #(
      .DEB_CNT   (DEB_CNT),
      .COOL_CYC  (COOL_CYC),
      .MAX_RETRY (MAX_RETRY),
      .GOOD_CNT  (GOOD_CNT)
    ) u_guard (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (chk_valid[i]),
      .fault_flag   (channel_fault[i]),
      .code         (fault_code[4*i +: 4]),
      .host_clear   (host_clear[i]),
      .enable       (ch_enable[i]),
      .state        (ch_state[3*i +: 3]),
      .sticky       (sticky_code[4*i +: 4]),
      .lockout      (lockout[i])
    );

    assign in_trip[i] = (ch_state[3*i +: 3] == ST_TRIP);
    assign not_ok[i]  = (ch_state[3*i +: 3] != ST_OK);
  end

  // Summary flags are decodes of the registered channel states
  assign irq       = |in_trip;
  assign fault_any = |not_ok;

endmodule
